alu_result_queue: RTL

//  Downstream stage of the combinational ALU top: captures each {result, flag} pair the ALU produces

---
 rtl/alu_result_queue_if.sv | 24 ++
 rtl/alu_result_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/alu_result_queue_if.sv
// Handshake bus between the ALU output and its result queue.
// master drives the upstream data plus the downstream ready; slave is the queue.
interface alu_result_queue_if #(
   parameter int WIDTH = 4
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_result;
   logic [3:0]       i_flag;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic [3:0]       o_flag;

   modport master (
      output i_valid, i_result, i_flag, i_ready,
      input  o_ready, o_valid, o_result, o_flag
   );

   modport slave (
      input  i_valid, i_result, i_flag, i_ready,
      output o_ready, o_valid, o_result, o_flag
   );
endinterface

// File: rtl/alu_result_queue.sv
// alu_result_queue: first-word-fall-through queue for {result, flag} pairs from
// the ALU, with saturating error/overflow statistics.
// Optional feature macro ALU_QUEUE_DROP_ERR_EN: error results (flag bit0) are
// accepted and counted but never stored.
module alu_result_queue #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   alu_result_queue_if.slave        q,
   input  logic                     i_clr_stats,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [CNT_W-1:0]         o_err_cnt,
   output logic [CNT_W-1:0]         o_ovf_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]    CNT_LAST  = CW'(DEPTH - 1);
   localparam logic [CNT_W-1:0] STAT_MAX  = '1;

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [WIDTH+3:0]  mem [DEPTH];
   logic              push, wr, pop, drop;

   // Handshake decode; stats follow the handshake, storage follows wr
   always_comb begin
      q.o_ready = (state != FULL);
      q.o_valid = (state != EMPTY);
      push      = q.i_valid & q.o_ready;
      pop       = q.o_valid & q.i_ready;
`ifdef ALU_QUEUE_DROP_ERR_EN
      drop      = q.i_flag[0];
`else
      drop      = 1'b0;
`endif
      wr        = push & ~drop;
   end

   // Occupancy FSM next-state
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (wr) state_nxt = PARTIAL;
         PARTIAL: begin
            if (wr && !pop && o_count == CNT_LAST)     state_nxt = FULL;
            else if (pop && !wr && o_count == CNT_ONE) state_nxt = EMPTY;
         end
         FULL:    if (pop) state_nxt = PARTIAL;
         default: state_nxt = EMPTY;
      endcase
   end

   // State, pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= EMPTY;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         state <= state_nxt;
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   o_count <= o_count + 1'b1;
            2'b01:   o_count <= o_count - 1'b1;
            default: o_count <= o_count;
         endcase
      end
   end

   // Storage array; contents are masked at the output while empty
   always_ff @(posedge i_clk) begin
      if (wr) mem[wr_ptr] <= {q.i_flag, q.i_result};
   end

   // Head entry falls through to the output
   always_comb begin
      q.o_result = '0;
      q.o_flag   = '0;
      if (q.o_valid) begin
         q.o_result = mem[rd_ptr][WIDTH-1:0];
         q.o_flag   = mem[rd_ptr][WIDTH+3:WIDTH];
      end
   end

   // Saturating statistics; clear wins over a same-cycle push
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr_stats) begin
         o_err_cnt <= '0;
         o_ovf_cnt <= '0;
      end else if (push) begin
         if (q.i_flag[0] && o_err_cnt != STAT_MAX) o_err_cnt <= o_err_cnt + 1'b1;
         if (q.i_flag[3] && o_ovf_cnt != STAT_MAX) o_ovf_cnt <= o_ovf_cnt + 1'b1;
      end
   end
endmodule
